// File: rtl/enemy_roam_sprite_rom.sv
// enemy_roam_sprite_rom
// 16x16 sprite ROM for the roaming enemy: (row, col) -> 8-bit RRRGGGBB colour,
// one cycle of latency, synchronous active-high reset to the transparent colour.
// The image is a diamond: a body fill, a 2-pixel outline, and two eyes.
// Optional build macro ENEMY_ROM_HIT_FLASH_EN adds a 'flash' input. While flash
// is high, every non-transparent pixel is shown white, as a hit indication.
module enemy_roam_sprite_rom #(
  parameter logic [7:0] TRANS_COLOR   = 8'hBB,
  parameter logic [7:0] BODY_COLOR    = 8'hE0,
  parameter logic [7:0] OUTLINE_COLOR = 8'h00,
  parameter logic [7:0] EYE_COLOR     = 8'hFC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic [3:0] col,
`ifdef ENEMY_ROM_HIT_FLASH_EN
  input  logic       flash,
`endif
  output logic [7:0] color_data
);

  // Pixel classes. The table stores a class rather than a colour, so the
  // colour parameters can be overridden without editing the table.
  localparam logic [1:0] CT = 2'd0;  // transparent
  localparam logic [1:0] CB = 2'd1;  // body
  localparam logic [1:0] CO = 2'd2;  // outline
  localparam logic [1:0] CE = 2'd3;  // eye

  localparam logic [7:0] FLASH_COLOR = 8'hFF;

  // Table index is {row, col}. Each line of the table is one sprite row.
  // d = |2r-15| + |2c-15|: d <= 14 is body, d of 16 or 18 is outline, and
  // anything larger is transparent. The eyes sit on row 5, at cols 5, 6, 9 and 10.
  localparam logic [1:0] CLASS_TABLE [256] = '{
    CT,CT,CT,CT,CT,CT,CO,CO,CO,CO,CT,CT,CT,CT,CT,CT,  // row 0
    CT,CT,CT,CT,CT,CO,CO,CB,CB,CO,CO,CT,CT,CT,CT,CT,  // row 1
    CT,CT,CT,CT,CO,CO,CB,CB,CB,CB,CO,CO,CT,CT,CT,CT,  // row 2
    CT,CT,CT,CO,CO,CB,CB,CB,CB,CB,CB,CO,CO,CT,CT,CT,  // row 3
    CT,CT,CO,CO,CB,CB,CB,CB,CB,CB,CB,CB,CO,CO,CT,CT,  // row 4
    CT,CO,CO,CB,CB,CE,CE,CB,CB,CE,CE,CB,CB,CO,CO,CT,  // row 5
    CO,CO,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CO,CO,  // row 6
    CO,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CO,  // row 7
    CO,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CO,  // row 8
    CO,CO,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CO,CO,  // row 9
    CT,CO,CO,CB,CB,CB,CB,CB,CB,CB,CB,CB,CB,CO,CO,CT,  // row 10
    CT,CT,CO,CO,CB,CB,CB,CB,CB,CB,CB,CB,CO,CO,CT,CT,  // row 11
    CT,CT,CT,CO,CO,CB,CB,CB,CB,CB,CB,CO,CO,CT,CT,CT,  // row 12
    CT,CT,CT,CT,CO,CO,CB,CB,CB,CB,CO,CO,CT,CT,CT,CT,  // row 13
    CT,CT,CT,CT,CT,CO,CO,CB,CB,CO,CO,CT,CT,CT,CT,CT,  // row 14
    CT,CT,CT,CT,CT,CT,CO,CO,CO,CO,CT,CT,CT,CT,CT,CT   // row 15
  };

  logic [7:0] addr;
  logic [1:0] pixel_class;
  logic [7:0] table_color;
  logic [7:0] next_color;
  logic       flash_on;

  assign addr        = {row, col};
  assign pixel_class = CLASS_TABLE[addr];

`ifdef ENEMY_ROM_HIT_FLASH_EN
  assign flash_on = flash;
`else
  assign flash_on = 1'b0;
`endif

  // Convert the stored pixel class into its colour.
  always_comb begin
    table_color = TRANS_COLOR;
    case (pixel_class)
      CT:      table_color = TRANS_COLOR;
      CB:      table_color = BODY_COLOR;
      CO:      table_color = OUTLINE_COLOR;
      CE:      table_color = EYE_COLOR;
      default: table_color = TRANS_COLOR;
    endcase
  end

  // Hit flash: show every visible pixel white, and leave transparent pixels alone.
  always_comb begin
    next_color = table_color;
    if (flash_on && (table_color != TRANS_COLOR)) begin
      next_color = FLASH_COLOR;
    end else begin
      next_color = table_color;
    end
  end

  // Register the output. Reset takes priority over the lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_data <= TRANS_COLOR;
    end else begin
      color_data <= next_color;
    end
  end

endmodule

// File: tb/tb_enemy_roam_sprite_rom.sv
// Directed bench for enemy_roam_sprite_rom. It checks the reset value, corners,
// eyes, latency, a full sweep against the d-rule model, mirror symmetry,
// reset in the middle of a stream, and the hit flash when
// ENEMY_ROM_HIT_FLASH_EN is defined.
module tb_enemy_roam_sprite_rom;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic       flash;
  logic [7:0] color_data;

  int errors = 0;
  int checks = 0;

  enemy_roam_sprite_rom dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
`ifdef ENEMY_ROM_HIT_FLASH_EN
    .flash      (flash),
`endif
    .color_data (color_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model: the d-rule with the eye override.
  function automatic logic [7:0] model(input int r, input int c);
    int dr;
    int dc;
    int d;
    dr = 2 * r - 15;
    dc = 2 * c - 15;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    d = dr + dc;
    if (r == 5 && (c == 5 || c == 6 || c == 9 || c == 10)) return 8'hFC;
    if (d <= 14) return 8'hE0;
    if (d <= 18) return 8'h00;
    return 8'hBB;
  endfunction

  // Drive an address, clock it in, and sample #1 after the edge.
  task automatic step(input int r, input int c);
    row = 4'(r);
    col = 4'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(7, 7);
    checks++;
    if (color_data !== 8'hBB) begin
      errors++;
      $display("FAIL reset_cycle1 got=%h exp=%h", color_data, 8'hBB);
    end
    step(7, 7);
    checks++;
    if (color_data !== 8'hBB) begin
      errors++;
      $display("FAIL reset_cycle2 got=%h exp=%h", color_data, 8'hBB);
    end
    rst = 1'b0;
    step(7, 7);
    checks++;
    if (color_data !== 8'hE0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", color_data, 8'hE0);
    end
  endtask

  task automatic test_corners();
    int rs [4] = '{0, 0, 1, 15};
    int cs [4] = '{0, 7, 7, 8};
    logic [7:0] ex [4] = '{8'hBB, 8'h00, 8'hE0, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(rs[i], cs[i]);
      checks++;
      if (color_data !== ex[i]) begin
        errors++;
        $display("FAIL corner(%0d,%0d) got=%h exp=%h", rs[i], cs[i], color_data, ex[i]);
      end
    end
  endtask

  task automatic test_eyes();
    int rs [6] = '{5, 5, 5, 5, 5, 4};
    int cs [6] = '{5, 6, 9, 10, 7, 5};
    logic [7:0] ex [6] = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hE0, 8'hE0};
    for (int i = 0; i < 6; i++) begin
      step(rs[i], cs[i]);
      checks++;
      if (color_data !== ex[i]) begin
        errors++;
        $display("FAIL eye(%0d,%0d) got=%h exp=%h", rs[i], cs[i], color_data, ex[i]);
      end
    end
  endtask

  // Change the address every clock. After each edge, present the next address
  // and check that the output still shows the previous sample.
  task automatic test_back_to_back();
    int rs [3] = '{0, 7, 5};
    int cs [3] = '{0, 7, 5};
    logic [7:0] ex [3] = '{8'hBB, 8'hE0, 8'hFC};
    row = 4'd0;
    col = 4'd0;
    for (int i = 0; i < 3; i++) begin
      row = 4'(rs[i]);
      col = 4'(cs[i]);
      @(posedge clk);
      #1;
      row = 4'(rs[(i + 1) % 3] + 1);
      col = 4'(cs[(i + 1) % 3] + 3);
      #2;
      checks++;
      if (color_data !== ex[i]) begin
        errors++;
        $display("FAIL latency%0d got=%h exp=%h", i, color_data, ex[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] seen [16][16];
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        step(r, c);
        seen[r][c] = color_data;
        checks++;
        if (color_data !== model(r, c)) begin
          errors++;
          $display("FAIL sweep(%0d,%0d) got=%h exp=%h", r, c, color_data, model(r, c));
        end
      end
    end
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (seen[r][c] !== seen[r][15 - c]) begin
          errors++;
          $display("FAIL mirror(%0d,%0d) got=%h exp=%h", r, c, seen[r][c], seen[r][15 - c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    step(7, 7);
    rst = 1'b1;
    step(5, 5);
    checks++;
    if (color_data !== 8'hBB) begin
      errors++;
      $display("FAIL midreset got=%h exp=%h", color_data, 8'hBB);
    end
    rst = 1'b0;
    step(5, 5);
    checks++;
    if (color_data !== 8'hFC) begin
      errors++;
      $display("FAIL midreset_resume got=%h exp=%h", color_data, 8'hFC);
    end
  endtask

`ifdef ENEMY_ROM_HIT_FLASH_EN
  task automatic test_flash();
    int rs [4] = '{7, 5, 0, 0};
    int cs [4] = '{7, 5, 0, 7};
    logic [7:0] ex [4] = '{8'hFF, 8'hFF, 8'hBB, 8'hFF};
    flash = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(rs[i], cs[i]);
      checks++;
      if (color_data !== ex[i]) begin
        errors++;
        $display("FAIL flash(%0d,%0d) got=%h exp=%h", rs[i], cs[i], color_data, ex[i]);
      end
    end
    rst = 1'b1;
    step(7, 7);
    checks++;
    if (color_data !== 8'hBB) begin
      errors++;
      $display("FAIL flash_reset got=%h exp=%h", color_data, 8'hBB);
    end
    rst = 1'b0;
    flash = 1'b0;
    step(7, 7);
    checks++;
    if (color_data !== 8'hE0) begin
      errors++;
      $display("FAIL flash_off got=%h exp=%h", color_data, 8'hE0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    row = 4'd0;
    col = 4'd0;
    flash = 1'b0;
    #2;
    test_reset();
    test_corners();
    test_eyes();
    test_back_to_back();
    test_sweep();
    test_reset_mid_stream();
`ifdef ENEMY_ROM_HIT_FLASH_EN
    test_flash();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
